// File: rtl/icache_dm_fill.sv
// Direct-mapped instruction cache with critical-word-first line refill, early
// forwarding of the requested word, a 1-deep request holding register and flush.
module icache_dm_fill #(
  parameter int ADDR_W         = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              send_pulse,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic              ack,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FINISH} state_t;
  state_t state, state_d;

  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  logic [TAG_W-1:0] cur_tag;
  logic [IDX_W-1:0] cur_idx;
  logic [OFF_W-1:0] cur_off, cnt, fill_off;
  logic             hold_valid, flush_pend;
  logic [WA_W-1:0]  hold_waddr;

  logic             serve_en, req_v, req_hit, do_hit, do_miss;
  logic             line_is_cur, line_valid, flush_eff, word_we, crit_we;
  logic [WA_W-1:0]  req_waddr;
  logic [TAG_W-1:0] req_tag, line_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr[1:0];

  // IDLE and FINISH share one lookup: the held request wins over a new pulse.
  assign serve_en  = (state == IDLE) || (state == FINISH);
  assign req_v     = hold_valid || send_pulse;
  assign req_waddr = hold_valid ? hold_waddr : addr[ADDR_W-1:2];
  assign req_off   = req_waddr[OFF_W-1:0];
  assign req_idx   = req_waddr[OFF_W +: IDX_W];
  assign req_tag   = req_waddr[WA_W-1 -: TAG_W];
  assign flush_eff = flush || flush_pend;

  // The line completing in FINISH is not yet marked in the arrays; bypass it.
  assign line_is_cur = (state == FINISH) && (req_idx == cur_idx);
  assign line_valid  = line_is_cur ? 1'b1 : valid_q[req_idx];
  assign line_tag    = line_is_cur ? cur_tag : tag_mem[req_idx];
  assign req_hit     = !flush_eff && line_valid && (line_tag == req_tag);
  assign do_hit      = serve_en && req_v && req_hit;
  assign do_miss     = serve_en && req_v && !req_hit;

  assign fill_off = cur_off + cnt;
  assign word_we  = (state == WAIT) && mem_valid;
  assign crit_we  = word_we && (cnt == '0);
  assign busy     = (state != IDLE) || hold_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state;
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state)
      IDLE:   if (do_miss) state_d = REQ;
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = {cur_tag, cur_idx, fill_off, 2'b00};
        state_d  = WAIT;
      end
      WAIT:   if (mem_valid) state_d = (cnt == LAST_CNT) ? FINISH : REQ;
      FINISH: state_d = do_miss ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_tag    <= '0;
      cur_idx    <= '0;
      cur_off    <= '0;
      cnt        <= '0;
      hold_valid <= 1'b0;
      hold_waddr <= '0;
      flush_pend <= 1'b0;
      valid_q    <= '0;
      ack        <= 1'b0;
      inst       <= '0;
    end else begin
      ack <= do_hit || crit_we;
      if (do_hit)       inst <= data_mem[{req_idx, req_off}];
      else if (crit_we) inst <= mem_rdata;

      if (do_miss) begin
        cur_tag <= req_tag;
        cur_idx <= req_idx;
        cur_off <= req_off;
        cnt     <= '0;
      end else if (word_we) begin
        cnt <= cnt + OFF_W'(1);
      end

      // A pulse arriving while a request is already held is dropped.
      if (serve_en) begin
        hold_valid <= hold_valid && send_pulse;
        if (send_pulse) hold_waddr <= addr[ADDR_W-1:2];
      end else if (send_pulse && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_waddr <= addr[ADDR_W-1:2];
      end

      if (state == FINISH)              flush_pend <= 1'b0;
      else if (state != IDLE && flush)  flush_pend <= 1'b1;

      if (serve_en && flush_eff) valid_q <= '0;
      else if (state == FINISH)  valid_q[cur_idx] <= 1'b1;
      if (do_miss)               valid_q[req_idx] <= 1'b0;
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (word_we)         data_mem[{cur_idx, fill_off}] <= mem_rdata;
    if (state == FINISH) tag_mem[cur_idx] <= cur_tag;
  end

endmodule
